// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle control path and its datapath.
// State enum, opcode constants, mux-select enums and the control bundle.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ALUB_RS2  = 2'b00,
        ALUB_FOUR = 2'b01,
        ALUB_IMM  = 2'b10
    } alusrc_b_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef struct packed {
        logic      mem_read;
        logic      mem_write;
        logic      iord;
        logic      ir_write;
        logic      pc_write;
        pc_src_e   pc_src;
        logic      branch;
        logic      alusrc_a;
        alusrc_b_e alusrc_b;
        aluop_e    aluop;
        logic      reg_write;
        wb_sel_e   wb_sel;
        logic      instr_retired;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        mem_read:      1'b0,
        mem_write:     1'b0,
        iord:          1'b0,
        ir_write:      1'b0,
        pc_write:      1'b0,
        pc_src:        PCSRC_ALU,
        branch:        1'b0,
        alusrc_a:      1'b0,
        alusrc_b:      ALUB_RS2,
        aluop:         ALUOP_ADD,
        reg_write:     1'b0,
        wb_sel:        WB_ALU,
        instr_retired: 1'b0
    };

    // Successor of DECODE; unknown opcodes (and JAL when disabled) trap.
    function automatic state_e decode_next(
        input logic [6:0] op,
        input bit         en_jal
    );
        case (op)
            OP_R:              return S_EXEC_R;
            OP_I:              return S_EXEC_I;
            OP_LOAD, OP_STORE: return S_MEM_ADDR;
            OP_BRANCH:         return S_BRANCH;
            OP_JAL:            return en_jal ? S_JAL : S_TRAP;
            default:           return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Memory request handshake between the control unit and memory.
// master: mem_read/mem_write out, mem_ready in; slave: the reverse.
interface multicycle_control_unit_if;

    logic mem_read;
    logic mem_write;
    logic mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        output mem_ready
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Wait-state counter for one outstanding memory request.
// Ports: clk, rst_n, active (request up), ready, timeout (limit reached).
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Held at zero outside a request, so every new request starts
    // from zero. A ready in the limit cycle still completes upstream.
    always_comb begin
        count_d = '0;
        if (active && !ready && !timeout) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout = (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: sequences the shared datapath per opcode.
// Ports: clk, reset (async low), run_en, opcode, mem (handshake),
// datapath selects, retire pulse/counter, sticky halt flags, halted.
module multicycle_control_unit
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32,
    parameter bit          ENABLE_JAL  = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run_en,
    input  logic [6:0]                opcode,
    multicycle_control_unit_if.master mem,
    output logic                      iord,
    output logic                      ir_write,
    output logic                      pc_write,
    output logic [1:0]                pc_src,
    output logic                      branch,
    output logic                      alusrc_a,
    output logic [1:0]                alusrc_b,
    output logic [1:0]                aluop,
    output logic                      reg_write,
    output logic [1:0]                wb_sel,
    output logic                      instr_retired,
    output logic [CNT_W-1:0]          retired_count,
    output logic                      illegal_instr,
    output logic                      bus_error,
    output logic                      halted
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             illegal_q;
    logic             illegal_d;
    logic             bus_err_q;
    logic             bus_err_d;
    ctrl_t            ctrl;
    ctrl_t            ctrl_o;
    logic             halt_c;
    logic             req_active;
    logic             timeout;

    assign req_active = (state_q == S_FETCH && run_en)
                     || (state_q == S_MEM_RD)
                     || (state_q == S_MEM_WR);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (reset),
        .active (req_active),
        .ready  (mem.mem_ready),
        .timeout(timeout)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        ctrl      = CTRL_IDLE;
        halt_c    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (run_en) begin
                    ctrl.mem_read = 1'b1;
                    ctrl.alusrc_b = ALUB_FOUR;
                    if (mem.mem_ready) begin
                        ctrl.ir_write = 1'b1;
                        ctrl.pc_write = 1'b1;
                        state_d       = S_DECODE;
                    end else if (timeout) begin
                        bus_err_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                end
            end
            S_DECODE: begin
                ctrl.alusrc_b = ALUB_IMM;
                state_d = decode_next(opcode, ENABLE_JAL);
                if (state_d == S_TRAP) begin
                    illegal_d = 1'b1;
                end
            end
            S_EXEC_R: begin
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = ALUB_RS2;
                ctrl.aluop    = ALUOP_FUNCT;
                state_d       = S_ALU_WB;
            end
            S_EXEC_I: begin
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = ALUB_IMM;
                ctrl.aluop    = ALUOP_FUNCT;
                state_d       = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.wb_sel        = WB_ALU;
                ctrl.instr_retired = 1'b1;
                state_d            = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = ALUB_IMM;
                state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                if (mem.mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_MEM_WB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.wb_sel        = WB_MEM;
                ctrl.instr_retired = 1'b1;
                state_d            = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                if (mem.mem_ready) begin
                    ctrl.instr_retired = 1'b1;
                    state_d            = S_FETCH;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_BRANCH: begin
                ctrl.alusrc_a      = 1'b1;
                ctrl.alusrc_b      = ALUB_RS2;
                ctrl.aluop         = ALUOP_SUB;
                ctrl.branch        = 1'b1;
                ctrl.pc_src        = PCSRC_BRANCH;
                ctrl.instr_retired = 1'b1;
                state_d            = S_FETCH;
            end
            S_JAL: begin
                ctrl.pc_write      = 1'b1;
                ctrl.pc_src        = PCSRC_JUMP;
                ctrl.reg_write     = 1'b1;
                ctrl.wb_sel        = WB_PC4;
                ctrl.instr_retired = 1'b1;
                state_d            = S_FETCH;
            end
            S_TRAP: begin
                halt_c = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    assign count_d = count_q + CNT_W'(ctrl.instr_retired);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            count_q   <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // The FSM sits in FETCH during reset; mask its request there.
    assign ctrl_o = reset ? ctrl : CTRL_IDLE;

    assign mem.mem_read  = ctrl_o.mem_read;
    assign mem.mem_write = ctrl_o.mem_write;
    assign iord          = ctrl_o.iord;
    assign ir_write      = ctrl_o.ir_write;
    assign pc_write      = ctrl_o.pc_write;
    assign pc_src        = ctrl_o.pc_src;
    assign branch        = ctrl_o.branch;
    assign alusrc_a      = ctrl_o.alusrc_a;
    assign alusrc_b      = ctrl_o.alusrc_b;
    assign aluop         = ctrl_o.aluop;
    assign reg_write     = ctrl_o.reg_write;
    assign wb_sel        = ctrl_o.wb_sel;
    assign instr_retired = ctrl_o.instr_retired;
    assign retired_count = count_q;
    assign illegal_instr = illegal_q;
    assign bus_error     = bus_err_q;
    assign halted        = reset & halt_c;

endmodule
